dds_phase_ctrl: RTL and testbench



---
 rtl/dds_phase_ctrl.sv | 157 +++++++++++++++
 tb/tb_dds_phase_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_ctrl.sv
// Dual-channel DDS phase accumulators, sine ROM addressing and DAC scaling.
// Optional gain multiplier is compiled in with DDS_AMP_SCALE_EN.
//
// Ports:
//   clk_125M            DAC sample clock, rising edge
//   reset               synchronous, active-high
//   wr_en/wr_addr/wr_data  register write port (0-4 shadow, 5 control)
//   rom1_addr/rom2_addr sine ROM addresses (registered)
//   rom1_data/rom2_data ROM samples, offset binary, 1-cycle latency
//   da1_data/da2_data   DAC samples, offset binary (registered)
//   busy                high the cycle a commit is applied

module dds_phase_ctrl #(
  parameter logic [31:0] FTW_RESET  = 32'h0040_0000,
  parameter logic [7:0]  GAIN_RESET = 8'hFF
) (
  input  logic        clk_125M,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic [9:0]  rom1_addr,
  output logic [9:0]  rom2_addr,
  input  logic [13:0] rom1_data,
  input  logic [13:0] rom2_data,
  output logic [13:0] da1_data,
  output logic [13:0] da2_data,
  output logic        busy
);

  localparam logic [13:0] MIDSCALE = 14'h2000;

  logic [31:0] r_sh_ftw1, r_sh_ftw2;
  logic [9:0]  r_sh_poff1, r_sh_poff2;
  logic [31:0] r_ftw1, r_ftw2;
  logic [9:0]  r_poff1, r_poff2;
  logic [31:0] r_acc1, r_acc2;
  logic        r_run;
  logic        r_commit;
  logic        r_sync;
  logic [13:0] r_da1, r_da2;
  logic [9:0]  r_rom1_addr, r_rom2_addr;

  logic        w_wr_ctrl;
  logic [13:0] w_da1, w_da2;

  assign w_wr_ctrl = wr_en && (wr_addr == 3'd5);

`ifdef DDS_AMP_SCALE_EN
  logic [7:0] r_sh_gain1, r_sh_gain2;
  logic [7:0] r_gain1, r_gain2;

  // Offset binary -> signed, times (gain+1), then /256.
  // |s*(g+1)| <= 2^21 so 23 bits cannot overflow.
  function automatic logic [13:0] scale(
    input logic [13:0] d,
    input logic [7:0]  g
  );
    logic signed [13:0] s;
    logic signed [9:0]  m;
    logic signed [22:0] p;
    s = $signed(d ^ MIDSCALE);
    m = $signed({2'b00, g} + 10'd1);
    p = 23'(s) * 23'(m);
    return 14'(p >>> 8) ^ MIDSCALE;
  endfunction

  assign w_da1 = scale(rom1_data, r_gain1);
  assign w_da2 = scale(rom2_data, r_gain2);

  always_ff @(posedge clk_125M) begin
    if (reset) begin
      r_sh_gain1 <= GAIN_RESET;
      r_sh_gain2 <= GAIN_RESET;
      r_gain1    <= GAIN_RESET;
      r_gain2    <= GAIN_RESET;
    end else begin
      if (wr_en && (wr_addr == 3'd4)) begin
        r_sh_gain1 <= wr_data[7:0];
        r_sh_gain2 <= wr_data[15:8];
      end
      if (r_commit) begin
        r_gain1 <= r_sh_gain1;
        r_gain2 <= r_sh_gain2;
      end
    end
  end
`else
  assign w_da1 = rom1_data;
  assign w_da2 = rom2_data;
`endif

  always_ff @(posedge clk_125M) begin
    if (reset) begin
      r_sh_ftw1   <= FTW_RESET;
      r_sh_ftw2   <= FTW_RESET;
      r_sh_poff1  <= '0;
      r_sh_poff2  <= '0;
      r_ftw1      <= FTW_RESET;
      r_ftw2      <= FTW_RESET;
      r_poff1     <= '0;
      r_poff2     <= '0;
      r_acc1      <= '0;
      r_acc2      <= '0;
      r_run       <= 1'b1;
      r_commit    <= 1'b0;
      r_sync      <= 1'b0;
      r_rom1_addr <= '0;
      r_rom2_addr <= '0;
      r_da1       <= MIDSCALE;
      r_da2       <= MIDSCALE;
    end else begin
      if (wr_en) begin
        case (wr_addr)
          3'd0:    r_sh_ftw1  <= wr_data;
          3'd1:    r_sh_ftw2  <= wr_data;
          3'd2:    r_sh_poff1 <= wr_data[9:0];
          3'd3:    r_sh_poff2 <= wr_data[9:0];
          default: ;
        endcase
      end

      // Commit/sync are one-cycle pulses; busy is the commit pulse.
      r_commit <= w_wr_ctrl & wr_data[1];
      r_sync   <= w_wr_ctrl & wr_data[2];
      if (w_wr_ctrl) r_run <= wr_data[0];

      if (r_commit) begin
        r_ftw1  <= r_sh_ftw1;
        r_ftw2  <= r_sh_ftw2;
        r_poff1 <= r_sh_poff1;
        r_poff2 <= r_sh_poff2;
      end

      if (r_sync) begin
        r_acc1 <= '0;
        r_acc2 <= '0;
      end else if (r_run) begin
        r_acc1 <= r_acc1 + r_ftw1;
        r_acc2 <= r_acc2 + r_ftw2;
      end

      r_rom1_addr <= r_acc1[31:22] + r_poff1;
      r_rom2_addr <= r_acc2[31:22] + r_poff2;

      r_da1 <= r_run ? w_da1 : MIDSCALE;
      r_da2 <= r_run ? w_da2 : MIDSCALE;
    end
  end

  assign rom1_addr = r_rom1_addr;
  assign rom2_addr = r_rom2_addr;
  assign da1_data  = r_da1;
  assign da2_data  = r_da2;
  assign busy      = r_commit;

endmodule

// File: tb/tb_dds_phase_ctrl.sv
// Scoreboard bench for dds_phase_ctrl with a registered ROM model.
// Expectations are queued per edge and checked 1 ns after that edge.

module tb_dds_phase_ctrl;

  logic        clk_125M = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rom1_addr, rom2_addr;
  logic [13:0] rom1_data, rom2_data;
  logic [13:0] da1_data, da2_data;
  logic        busy;

  logic        rom_const_en;
  logic [13:0] rom_const;

  dds_phase_ctrl dut (
    .clk_125M  (clk_125M),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rom1_addr (rom1_addr),
    .rom2_addr (rom2_addr),
    .rom1_data (rom1_data),
    .rom2_data (rom2_data),
    .da1_data  (da1_data),
    .da2_data  (da2_data),
    .busy      (busy)
  );

  always #4 clk_125M = ~clk_125M;

  always @(posedge clk_125M) begin
    rom1_data <= rom_const_en ? rom_const : {4'b0, rom1_addr};
    rom2_data <= rom_const_en ? rom_const : {4'b0, rom2_addr};
  end

  typedef struct {
    int          at;
    int          sig;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   e = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] probe(input int sig);
    case (sig)
      0:       return {22'b0, rom1_addr};
      1:       return {22'b0, rom2_addr};
      2:       return {18'b0, da1_data};
      3:       return {18'b0, da2_data};
      default: return {31'b0, busy};
    endcase
  endfunction

  always @(posedge clk_125M) begin
    e = e + 1;
    #1;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at <= e) begin
        check(q[i].tag, probe(q[i].sig), q[i].val);
        q.delete(i);
      end
    end
  end

  task automatic push(input int at, input int sig, input int val,
                      input string tag);
    exp_t x;
    x.at  = at;
    x.sig = sig;
    x.val = val;
    x.tag = tag;
    q.push_back(x);
  endtask

  task automatic wr_begin(input logic [2:0] a, input logic [31:0] d,
                          output int t);
    @(negedge clk_125M);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    t = e + 1;
  endtask

  task automatic wr_end();
    @(negedge clk_125M);
    wr_en = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    int t;
    wr_begin(a, d, t);
    wr_end();
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && q.size() > 0; i++)
      @(negedge clk_125M);
    if (q.size() > 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  int t, r0, s, u, a, r2;

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rom_const_en = 1'b0;
    rom_const = '0;

    // Reset values
    @(negedge clk_125M);
    t = e + 1;
    push(t, 0, 0, "rst_rom1");
    push(t, 1, 0, "rst_rom2");
    push(t, 2, 14'h2000, "rst_da1");
    push(t, 3, 14'h2000, "rst_da2");
    push(t, 4, 0, "rst_busy");
    @(negedge clk_125M);
    reset = 1'b0;
    r0 = e + 1;

    // Free run: step 1, wrap 1023->0, DAC lags by 2
    for (int k = 0; k < 1030; k++) begin
      if (k < 6 || k >= 1020) begin
        push(r0 + k, 0, k & 1023, $sformatf("run_rom1_%0d", k));
        push(r0 + k, 1, k & 1023, $sformatf("run_rom2_%0d", k));
        if (k >= 2) begin
          push(r0 + k, 2, (k - 2) & 1023, $sformatf("run_da1_%0d", k));
          push(r0 + k, 3, (k - 2) & 1023, $sformatf("run_da2_%0d", k));
        end
      end
    end
    drain();

    // FTW1 = 128 steps, commit
    wr(3'd0, 32'h2000_0000);
    wr_begin(3'd5, 32'h3, t);
    push(t, 4, 1, "cmt_busy_hi");
    push(t + 1, 4, 0, "cmt_busy_lo");
    push(t + 1, 0, (t + 1 - r0) & 1023, "cmt_rom1_t1");
    push(t + 2, 0, (t + 2 - r0) & 1023, "cmt_rom1_t2");
    push(t + 3, 0, (t + 2 - r0 + 128) & 1023, "cmt_rom1_t3");
    push(t + 4, 0, (t + 2 - r0 + 256) & 1023, "cmt_rom1_t4");
    for (int j = 1; j <= 4; j++)
      push(t + j, 1, (t + j - r0) & 1023, $sformatf("cmt_rom2_%0d", j));
    wr_end();
    drain();

    // FTW2 = 128 steps, poff2 = 256, commit+sync together
    wr(3'd1, 32'h2000_0000);
    wr(3'd3, 32'd256);
    wr_begin(3'd5, 32'h7, t);
    push(t, 4, 1, "cs_busy");
    for (int m = 0; m < 5; m++) begin
      push(t + 2 + m, 0, (128 * m) & 1023, $sformatf("cs_rom1_%0d", m));
      push(t + 2 + m, 1, (256 + 128 * m) & 1023, $sformatf("cs_rom2_%0d", m));
    end
    for (int m = 0; m < 3; m++) begin
      push(t + 4 + m, 2, (128 * m) & 1023, $sformatf("cs_da1_%0d", m));
      push(t + 4 + m, 3, (256 + 128 * m) & 1023, $sformatf("cs_da2_%0d", m));
    end
    wr_end();
    drain();

    // Gain CH1 = 127 on full-scale and zero samples
    wr(3'd4, 32'h0000_FF7F);
    rom_const_en = 1'b1;
    rom_const = 14'h3FFF;
    wr_begin(3'd5, 32'h3, t);
    push(t + 1, 2, 14'h3FFF, "g127_da1_old");
`ifdef DDS_AMP_SCALE_EN
    push(t + 2, 2, 14'h2FFF, "g127_da1_max");
`else
    push(t + 2, 2, 14'h3FFF, "g127_da1_max");
`endif
    push(t + 2, 3, 14'h3FFF, "g127_da2_max");
    wr_end();
    drain();
    rom_const = 14'h0000;
    t = e + 2;
`ifdef DDS_AMP_SCALE_EN
    push(t, 2, 14'h1000, "g127_da1_min");
`else
    push(t, 2, 14'h0000, "g127_da1_min");
`endif
    push(t, 3, 14'h0000, "g127_da2_min");
    drain();

    // Gain CH1 = 0 gives s/256
    wr(3'd4, 32'h0000_FF00);
    rom_const = 14'h3FFF;
    wr_begin(3'd5, 32'h3, t);
`ifdef DDS_AMP_SCALE_EN
    push(t + 2, 2, 14'h201F, "g0_da1");
`else
    push(t + 2, 2, 14'h3FFF, "g0_da1");
`endif
    wr_end();
    drain();
    wr(3'd4, 32'h0000_FFFF);
    wr(3'd5, 32'h3);
    rom_const_en = 1'b0;
    repeat (4) @(negedge clk_125M);

    // Pause mid-wave, then resume
    wr_begin(3'd5, 32'h5, s);
    wr_end();
    repeat (3) @(negedge clk_125M);
    wr_begin(3'd5, 32'h0, t);
    a = (128 * (t - s - 1)) & 1023;
    for (int j = 1; j <= 4; j++) begin
      push(t + j, 0, a, $sformatf("pz_rom1_%0d", j));
      push(t + j, 1, (a + 256) & 1023, $sformatf("pz_rom2_%0d", j));
      if (j >= 2) begin
        push(t + j, 2, 14'h2000, $sformatf("pz_da1_%0d", j));
        push(t + j, 3, 14'h2000, $sformatf("pz_da2_%0d", j));
      end
    end
    wr_end();
    repeat (2) @(negedge clk_125M);
    wr_begin(3'd5, 32'h1, u);
    for (int j = 1; j <= 3; j++) begin
      push(u + j, 0, (a + 128 * (j - 1)) & 1023, $sformatf("rs_rom1_%0d", j));
      push(u + j, 1, (a + 256 + 128 * (j - 1)) & 1023,
           $sformatf("rs_rom2_%0d", j));
    end
    push(u + 4, 2, (a + 128) & 1023, "rs_da1");
    push(u + 4, 3, (a + 384) & 1023, "rs_da2");
    wr_end();
    drain();

    // Reset with an uncommitted shadow FTW pending
    wr(3'd0, 32'h1000_0000);
    @(negedge clk_125M);
    reset = 1'b1;
    t = e + 1;
    push(t, 0, 0, "mr_rom1");
    push(t, 1, 0, "mr_rom2");
    push(t, 2, 14'h2000, "mr_da1");
    push(t, 3, 14'h2000, "mr_da2");
    push(t, 4, 0, "mr_busy");
    @(negedge clk_125M);
    reset = 1'b0;
    r2 = e + 1;
    for (int k = 0; k < 5; k++) begin
      push(r2 + k, 0, k, $sformatf("mr_run_rom1_%0d", k));
      push(r2 + k, 1, k, $sformatf("mr_run_rom2_%0d", k));
      if (k >= 2)
        push(r2 + k, 2, k - 2, $sformatf("mr_run_da1_%0d", k));
    end
    drain();
    wr_begin(3'd5, 32'h3, t);
    push(t + 3, 0, (t + 3 - r2) & 1023, "mr_cmt_rom1_3");
    push(t + 4, 0, (t + 4 - r2) & 1023, "mr_cmt_rom1_4");
    wr_end();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
